sample_pacer: RTL and testbench

Buffers 16-bit signed audio samples from the UART streamer and releases them at a programmable sample rate as 8-bit unsigned PWM duty values. Sits between the streamer's stream/valid output and the PWM duty-cycle input. Absorbs UART burstiness with a priming threshold, and reports fill, underrun and overflow status for the register file.

---
 rtl/sample_pacer_pkg.sv | 38 +++
 rtl/sample_pacer_if.sv | 11 +
 rtl/sample_pacer_fifo.sv | 67 ++++++
 rtl/sample_pacer.sv | 158 +++++++++++++++
 tb/tb_sample_pacer.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sample_pacer_pkg.sv
// Shared types and helpers for the sample pacer: playback states, the status and
// control register fields it exposes, and a saturating counter increment.
package sample_pacer_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_DEPTH_LOG2 = 8;
    localparam int DEF_DIV_WIDTH  = 16;
    localparam int COUNTER_WIDTH  = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRIMING = 2'd1,
        RUNNING = 2'd2
    } PACER_STATE;

    // Read-side status, packed for inclusion in RD_REGISTERS.
    typedef struct packed {
        logic [DEF_DEPTH_LOG2:0]    FillLevel;
        logic [COUNTER_WIDTH-1:0]   UnderrunCount;
        logic [COUNTER_WIDTH-1:0]   OverflowCount;
    } PACER_STATUS;

    // Control fields carried in WR_REGISTERS.
    typedef struct packed {
        logic                       Enable;
        logic                       Flush;
        logic [DEF_DIV_WIDTH-1:0]   RateDiv;
    } PACER_CONTROL;

    function automatic logic [COUNTER_WIDTH-1:0] satIncrement(input logic [COUNTER_WIDTH-1:0] value);
        if (value == {COUNTER_WIDTH{1'b1}}) begin
            return value;
        end else begin
            return value + COUNTER_WIDTH'(1);
        end
    endfunction

endpackage

// File: rtl/sample_pacer_if.sv
// Sample stream from the UART streamer into the pacer: data/valid forward, ready back.
interface sample_pacer_if #(
    parameter int DATA_WIDTH = 16
);
    logic [DATA_WIDTH-1:0]  ipSample;
    logic                   ipValid;
    logic                   opReady;

    modport master (output ipSample, output ipValid, input opReady);
    modport slave  (input ipSample, input ipValid, output opReady);
endinterface

// File: rtl/sample_pacer_fifo.sv
// Synchronous sample FIFO with flush; full/empty come from an extra-bit occupancy count
// so a full buffer reports 2**DEPTH_LOG2. Head read is combinational from the array.
module sample_fifo #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH_LOG2 = 8,
    parameter int HEAD_WIDTH = 8
) (
    input  logic                    ipClk,
    input  logic                    ipReset,
    input  logic                    flush,
    input  logic                    write,
    input  logic [DATA_WIDTH-1:0]   writeData,
    input  logic                    pop,
    output logic [HEAD_WIDTH-1:0]   headData,
    output logic [DEPTH_LOG2:0]     count,
    output logic                    full,
    output logic                    empty
);
    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE    = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1);

    logic [DATA_WIDTH-1:0]  mem_r [DEPTH];
    logic [DEPTH_LOG2-1:0]  wrPtr_r;
    logic [DEPTH_LOG2-1:0]  rdPtr_r;
    logic [DEPTH_LOG2:0]    count_r;
    logic                   doWrite_s;
    logic                   doPop_s;

    // A full FIFO refuses the write even when a pop frees a slot in the same cycle.
    assign full      = (count_r == FULL_COUNT);
    assign empty     = (count_r == {(DEPTH_LOG2 + 1){1'b0}});
    assign doWrite_s = write && !full && !flush;
    assign doPop_s   = pop && !empty && !flush;
    assign count     = count_r;
    assign headData  = mem_r[rdPtr_r][DATA_WIDTH-1 -: HEAD_WIDTH];

    // Pointer and occupancy tracking; flush and reset both return to empty.
    always_ff @(posedge ipClk) begin
        if (ipReset || flush) begin
            wrPtr_r <= {DEPTH_LOG2{1'b0}};
            rdPtr_r <= {DEPTH_LOG2{1'b0}};
            count_r <= {(DEPTH_LOG2 + 1){1'b0}};
        end else begin
            if (doWrite_s) begin
                wrPtr_r <= wrPtr_r + PTR_ONE;
            end
            if (doPop_s) begin
                rdPtr_r <= rdPtr_r + PTR_ONE;
            end
            case ({doWrite_s, doPop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Sample storage write port.
    always_ff @(posedge ipClk) begin
        if (doWrite_s) begin
            mem_r[wrPtr_r] <= writeData;
        end
    end

endmodule

// File: rtl/sample_pacer.sv
// Paces buffered signed audio samples out as offset-binary PWM duty values at a
// programmable rate, with priming, underrun/overflow accounting and flush.
module sample_pacer
    import sample_pacer_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int DEPTH_LOG2  = 8,
    parameter int PRIME_LEVEL = 128,
    parameter int DIV_WIDTH   = 16,
    parameter int DUTY_WIDTH  = 8
) (
    input  logic                    ipClk,
    input  logic                    ipReset,
    sample_pacer_if.slave           stream,
    input  logic                    ipEnable,
    input  logic                    ipFlush,
    input  logic [DIV_WIDTH-1:0]    ipRateDiv,
    output logic [DUTY_WIDTH-1:0]   opDutyCycle,
    output logic                    opDutyStrobe,
    output logic [DEPTH_LOG2:0]     opFillLevel,
    output logic [15:0]             opUnderrunCount,
    output logic [15:0]             opOverflowCount
);
    localparam logic [DUTY_WIDTH-1:0] DUTY_MID    = {1'b1, {(DUTY_WIDTH - 1){1'b0}}};
    localparam logic [DEPTH_LOG2:0]   PRIME_COUNT = (DEPTH_LOG2 + 1)'(PRIME_LEVEL);
    localparam logic [DIV_WIDTH-1:0]  DIV_ONE     = DIV_WIDTH'(1);

    PACER_STATE             state_r;
    PACER_STATE             stateNext_s;
    logic [DIV_WIDTH-1:0]   rateCnt_r;
    logic [DIV_WIDTH-1:0]   rateCntNext_s;
    logic                   tick_s;
    logic                   popReq_s;
    logic                   underrun_s;
    logic                   overflow_s;
    logic [DUTY_WIDTH-1:0]  headData_s;
    logic [DEPTH_LOG2:0]    count_s;
    logic                   full_s;
    logic                   empty_s;
    logic [DUTY_WIDTH-1:0]  dutyNext_s;
    logic                   strobeNext_s;
    logic [DUTY_WIDTH-1:0]  duty_r;
    logic                   strobe_r;
    logic [15:0]            underrunCnt_r;
    logic [15:0]            overflowCnt_r;

    sample_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2),
        .HEAD_WIDTH (DUTY_WIDTH)
    ) u_fifo (
        .ipClk      (ipClk),
        .ipReset    (ipReset),
        .flush      (ipFlush),
        .write      (stream.ipValid),
        .writeData  (stream.ipSample),
        .pop        (popReq_s),
        .headData   (headData_s),
        .count      (count_s),
        .full       (full_s),
        .empty      (empty_s)
    );

    assign popReq_s        = tick_s && !empty_s;
    assign underrun_s      = tick_s && empty_s;
    assign overflow_s      = stream.ipValid && full_s;
    assign stream.opReady  = !full_s;
    assign opFillLevel     = count_s;
    assign opDutyCycle     = duty_r;
    assign opDutyStrobe    = strobe_r;
    assign opUnderrunCount = underrunCnt_r;
    assign opOverflowCount = overflowCnt_r;

    // Playback state and rate divider; the divider only runs while RUNNING.
    always_comb begin
        stateNext_s   = state_r;
        rateCntNext_s = ipRateDiv;
        tick_s        = 1'b0;
        case (state_r)
            IDLE: begin
                if (ipEnable) begin
                    stateNext_s = PRIMING;
                end else begin
                    stateNext_s = IDLE;
                end
            end
            PRIMING: begin
                if (!ipEnable) begin
                    stateNext_s = IDLE;
                end else if (!ipFlush && (count_s >= PRIME_COUNT)) begin
                    stateNext_s = RUNNING;
                end else begin
                    stateNext_s = PRIMING;
                end
            end
            RUNNING: begin
                if (!ipEnable) begin
                    stateNext_s = IDLE;
                end else if (ipFlush) begin
                    stateNext_s = PRIMING;
                end else if (rateCnt_r == {DIV_WIDTH{1'b0}}) begin
                    // Tick: an empty FIFO here is an underrun and forces re-priming.
                    tick_s      = 1'b1;
                    stateNext_s = empty_s ? PRIMING : RUNNING;
                end else begin
                    rateCntNext_s = rateCnt_r - DIV_ONE;
                    stateNext_s   = RUNNING;
                end
            end
            default: begin
                stateNext_s = IDLE;
            end
        endcase
    end

    // Duty update: mid-scale whenever playback is not continuing, new sample on a pop.
    always_comb begin
        dutyNext_s   = duty_r;
        strobeNext_s = 1'b0;
        if (stateNext_s != RUNNING) begin
            dutyNext_s   = DUTY_MID;
            strobeNext_s = 1'b0;
        end else if (popReq_s) begin
            dutyNext_s   = {~headData_s[DUTY_WIDTH-1], headData_s[DUTY_WIDTH-2:0]};
            strobeNext_s = 1'b1;
        end else begin
            dutyNext_s   = duty_r;
            strobeNext_s = 1'b0;
        end
    end

    // State register and rate counter.
    always_ff @(posedge ipClk) begin
        if (ipReset) begin
            state_r   <= IDLE;
            rateCnt_r <= ipRateDiv;
        end else begin
            state_r   <= stateNext_s;
            rateCnt_r <= rateCntNext_s;
        end
    end

    // Registered duty output and saturating status counters.
    always_ff @(posedge ipClk) begin
        if (ipReset) begin
            duty_r        <= DUTY_MID;
            strobe_r      <= 1'b0;
            underrunCnt_r <= 16'h0000;
            overflowCnt_r <= 16'h0000;
        end else begin
            duty_r        <= dutyNext_s;
            strobe_r      <= strobeNext_s;
            underrunCnt_r <= underrun_s ? satIncrement(underrunCnt_r) : underrunCnt_r;
            overflowCnt_r <= overflow_s ? satIncrement(overflowCnt_r) : overflowCnt_r;
        end
    end

endmodule

// File: tb/tb_sample_pacer.sv
// Self-checking bench for sample_pacer: directed scenarios with constant expectations
// plus randomized traffic compared every cycle against a queue-based reference model.
module tb_sample_pacer;

    logic        ipClk = 1'b0;
    logic        ipReset;
    logic        ipEnable;
    logic        ipFlush;
    logic [15:0] ipRateDiv;
    logic [7:0]  opDutyCycle;
    logic        opDutyStrobe;
    logic [8:0]  opFillLevel;
    logic [15:0] opUnderrunCount;
    logic [15:0] opOverflowCount;

    sample_pacer_if #(.DATA_WIDTH(16)) streamIf ();

    sample_pacer dut (
        .ipClk           (ipClk),
        .ipReset         (ipReset),
        .stream          (streamIf),
        .ipEnable        (ipEnable),
        .ipFlush         (ipFlush),
        .ipRateDiv       (ipRateDiv),
        .opDutyCycle     (opDutyCycle),
        .opDutyStrobe    (opDutyStrobe),
        .opFillLevel     (opFillLevel),
        .opUnderrunCount (opUnderrunCount),
        .opOverflowCount (opOverflowCount)
    );

    always #5 ipClk = ~ipClk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Reference model: FIFO as a queue, playback phase, age within the current run.
    logic [15:0] mq[$];
    int          mMode;     // 0 = idle, 1 = priming, 2 = running
    int          mAge;
    logic [7:0]  mDuty;
    logic        mStrobe;
    int          mUnder;
    int          mOver;
    bit          curEn;
    logic [15:0] curRd;

    task automatic modelStep(input bit rst, input bit v, input logic [15:0] s, input bit en, input bit fl, input int rd);
        bit          full;
        bit          tick;
        bit          popped;
        int          nextMode;
        logic [15:0] head;
        if (rst) begin
            mq.delete();
            mMode = 0; mAge = 0; mDuty = 8'h80; mStrobe = 1'b0; mUnder = 0; mOver = 0;
            return;
        end
        full   = (mq.size() == 256);
        tick   = (mMode == 2) && en && !fl && ((mAge % (rd + 1)) == rd);
        popped = tick && (mq.size() > 0);
        if (v && full) mOver = (mOver == 65535) ? mOver : mOver + 1;
        if (tick && !popped) mUnder = (mUnder == 65535) ? mUnder : mUnder + 1;
        if (!en)                     nextMode = 0;
        else if (mMode == 0)         nextMode = 1;
        else if (fl)                 nextMode = 1;
        else if (mMode == 1)         nextMode = (mq.size() >= 128) ? 2 : 1;
        else if (tick && !popped)    nextMode = 1;
        else                         nextMode = 2;
        head = 16'h0000;
        if (popped) head = mq.pop_front();
        if (fl) mq.delete();
        else if (v && !full) mq.push_back(s);
        if (nextMode != 2) begin
            mDuty = 8'h80; mStrobe = 1'b0;
        end else if (popped) begin
            mDuty = 8'((int'($signed(head)) + 32768) >> 8);
            mStrobe = 1'b1;
        end else begin
            mStrobe = 1'b0;
        end
        mAge  = (nextMode == 2 && mMode == 2) ? mAge + 1 : 0;
        mMode = nextMode;
    endtask

    task automatic compareModel();
        check("model duty", opDutyCycle, mDuty);
        check("model strobe", opDutyStrobe, mStrobe);
        check("model fill", opFillLevel, mq.size());
        check("model ready", streamIf.opReady, (mq.size() != 256));
        check("model underrun", opUnderrunCount, mUnder);
        check("model overflow", opOverflowCount, mOver);
    endtask

    // One clock: drive at negedge, advance model, compare after the next posedge.
    task automatic step(input bit rst, input bit v, input logic [15:0] s, input bit fl);
        ipReset           = rst;
        streamIf.ipValid  = v;
        streamIf.ipSample = s;
        ipEnable          = curEn;
        ipFlush           = fl;
        ipRateDiv         = curRd;
        modelStep(rst, v, s, curEn, fl, int'(curRd));
        @(posedge ipClk);
        @(negedge ipClk);
        compareModel();
    endtask

    task automatic waitStrobe(input int budget, output int waited, output bit seen);
        seen = 1'b0;
        waited = 0;
        while (!seen && waited < budget) begin
            step(1'b0, 1'b0, 16'h0000, 1'b0);
            waited++;
            seen = opDutyStrobe;
        end
    endtask

    typedef struct {
        logic [15:0] sample;
        logic [7:0]  duty;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  waited;
        bit  seen;
        int  strobeTotal;
        int  cyc;
        int  badDuty;
        int  rdSeg[4];
        int  pctSeg[4];

        vecs[0] = '{16'h1234, 8'h92};
        vecs[1] = '{16'h8000, 8'h00};
        vecs[2] = '{16'h7FFF, 8'hFF};
        vecs[3] = '{16'hFFFF, 8'h7F};
        vecs[4] = '{16'h0000, 8'h80};
        vecs[5] = '{16'h00FF, 8'h80};
        vecs[6] = '{16'hC3A5, 8'h43};
        vecs[7] = '{16'h5A00, 8'hDA};

        curEn = 1'b0;
        curRd = 16'd3;
        @(negedge ipClk);

        // 1: reset values, then enabled with no data stays silent in priming.
        step(1'b1, 1'b0, 16'h0000, 1'b0);
        check("reset duty", opDutyCycle, 8'h80);
        check("reset strobe", opDutyStrobe, 1'b0);
        check("reset ready", streamIf.opReady, 1'b1);
        check("reset fill", opFillLevel, 9'd0);
        check("reset underrun", opUnderrunCount, 16'd0);
        check("reset overflow", opOverflowCount, 16'd0);
        curEn = 1'b1;
        strobeTotal = 0;
        badDuty = 0;
        for (int i = 0; i < 300; i++) begin
            step(1'b0, 1'b0, 16'h0000, 1'b0);
            if (opDutyStrobe) strobeTotal++;
            if (opDutyCycle != 8'h80) badDuty++;
        end
        check("t1 strobes while priming", strobeTotal, 0);
        check("t1 non-mid duty cycles", badDuty, 0);
        check("t1 underrun", opUnderrunCount, 16'd0);

        // 2: table of samples through the pacer at rate divider 3.
        step(1'b1, 1'b0, 16'h0000, 1'b0);
        for (int i = 0; i < 128; i++) begin
            step(1'b0, 1'b1, (i < 8) ? vecs[i].sample : 16'(i * 515), 1'b0);
        end
        check("t2 fill after priming writes", opFillLevel, 9'd128);
        for (int k = 0; k < 8; k++) begin
            waitStrobe(12, waited, seen);
            check("t2 strobe seen", seen, 1'b1);
            check("t2 strobe spacing", waited, (k == 0) ? 5 : 4);
            check("t2 duty", opDutyCycle, vecs[k].duty);
        end

        // 3: drain to underrun, then re-prime and resume.
        strobeTotal = 8;
        cyc = 0;
        while (opUnderrunCount == 16'd0 && cyc < 700) begin
            step(1'b0, 1'b0, 16'h0000, 1'b0);
            cyc++;
            if (opDutyStrobe) strobeTotal++;
        end
        check("t3 strobes before underrun", strobeTotal, 128);
        check("t3 underrun count", opUnderrunCount, 16'd1);
        check("t3 underrun duty", opDutyCycle, 8'h80);
        check("t3 underrun strobe", opDutyStrobe, 1'b0);
        strobeTotal = 0;
        for (int i = 0; i < 128; i++) begin
            step(1'b0, 1'b1, (i == 0) ? 16'hA5A5 : 16'(i), 1'b0);
            if (opDutyStrobe) strobeTotal++;
        end
        check("t3 strobes while re-priming", strobeTotal, 0);
        check("t3 fill after re-prime", opFillLevel, 9'd128);
        waitStrobe(12, waited, seen);
        check("t3 resume seen", seen, 1'b1);
        check("t3 resume latency", waited, 5);
        check("t3 resume duty", opDutyCycle, 8'h25);

        // 4: disabled, overfill to 260 writes.
        step(1'b1, 1'b0, 16'h0000, 1'b0);
        curEn = 1'b0;
        for (int i = 0; i < 260; i++) begin
            step(1'b0, 1'b1, 16'(i * 257), 1'b0);
            if (i == 254) check("t4 ready after 255", streamIf.opReady, 1'b1);
            if (i == 255) check("t4 ready after 256", streamIf.opReady, 1'b0);
        end
        check("t4 fill", opFillLevel, 9'd256);
        check("t4 overflow", opOverflowCount, 16'd4);

        // 5: rate 0 from full with valid held: strobe every cycle, then flush.
        curRd = 16'd0;
        curEn = 1'b1;
        step(1'b0, 1'b1, 16'h1111, 1'b0);
        step(1'b0, 1'b1, 16'h2222, 1'b0);
        check("t5 no strobe before running", opDutyStrobe, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b1, 16'($urandom), 1'b0);
            check("t5 strobe each cycle", opDutyStrobe, 1'b1);
            check("t5 fill steady", opFillLevel, 9'd255);
        end
        check("t5 overflow", opOverflowCount, 16'd7);
        step(1'b0, 1'b1, 16'h3333, 1'b1);
        check("t5 flush fill", opFillLevel, 9'd0);
        check("t5 flush duty", opDutyCycle, 8'h80);
        check("t5 flush overflow kept", opOverflowCount, 16'd7);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 16'h0000, 1'b0);
        check("t5 priming after flush (no underrun)", opUnderrunCount, 16'd0);

        // 6: reset during playback with a write in the reset cycle.
        for (int i = 0; i < 130; i++) step(1'b0, 1'b1, 16'(i + 100), 1'b0);
        waitStrobe(10, waited, seen);
        check("t6 playing", seen, 1'b1);
        step(1'b1, 1'b1, 16'h7777, 1'b0);
        check("t6 reset duty", opDutyCycle, 8'h80);
        check("t6 reset strobe", opDutyStrobe, 1'b0);
        check("t6 reset fill", opFillLevel, 9'd0);
        check("t6 reset overflow", opOverflowCount, 16'd0);
        check("t6 reset underrun", opUnderrunCount, 16'd0);
        curEn = 1'b0;
        step(1'b0, 1'b0, 16'h0000, 1'b0);
        check("t6 reset-cycle write absent", opFillLevel, 9'd0);

        // Randomized segments, each checked cycle by cycle against the model.
        rdSeg  = '{3, 0, 5, 1};
        pctSeg = '{60, 40, 90, 45};
        for (int seg = 0; seg < 4; seg++) begin
            curRd = 16'(rdSeg[seg]);
            step(1'b1, 1'b0, 16'h0000, 1'b0);
            for (int i = 0; i < 2000; i++) begin
                curEn = ($urandom_range(0, 299) != 0);
                step(1'b0, ($urandom_range(0, 99) < pctSeg[seg]), 16'($urandom),
                     ($urandom_range(0, 399) == 0));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
